// File: rtl/level_pkg.sv
// Shared phase encodings and stage-width helper for the level sequencer.
package level_pkg;

    localparam logic [1:0] PH_DRAW = 2'd0;
    localparam logic [1:0] PH_PLAY = 2'd1;
    localparam logic [1:0] PH_DONE = 2'd2;

    // Stage counts 0..num_stages inclusive, hence the +1.
    function automatic int calc_sw(input int num_stages);
        return $clog2(num_stages + 1);
    endfunction

endpackage

// File: rtl/coord_match.sv
// Combinational sprite-position comparators against every activation point and the goal.
module coord_match #(
    parameter int NUM_STAGES = 4,
    parameter int X_W        = 9,
    parameter int Y_W        = 8
) (
    input  logic [X_W-1:0]            i_sprite_x,
    input  logic [Y_W-1:0]            i_sprite_y,
    input  logic [NUM_STAGES*X_W-1:0] i_act_x,
    input  logic [NUM_STAGES*Y_W-1:0] i_act_y,
    input  logic [X_W-1:0]            i_goal_x,
    input  logic [Y_W-1:0]            i_goal_y,
    output logic [NUM_STAGES-1:0]     o_at,
    output logic                      o_at_goal
);

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        o_at = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            o_at[k] = (i_sprite_x == i_act_x[k*X_W +: X_W]) &&
                      (i_sprite_y == i_act_y[k*Y_W +: Y_W]);
        end
    end

    assign o_at_goal = (i_sprite_x == i_goal_x) && (i_sprite_y == i_goal_y);

endmodule

// File: rtl/level_sequencer.sv
// Level FSM: walks a puzzle level through its activation points and handshakes
// each stage change with the map drawer.
module level_sequencer
    import level_pkg::*;
#(
    parameter int NUM_STAGES     = 4,
    parameter int X_W            = 9,
    parameter int Y_W            = 8,
    parameter int GOAL_NEEDS_ACT = 0,
    parameter int DEAD_RESTART   = 1
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            activate,
    input  logic                            sprite_dead,
    input  logic                            done_redraw,
    input  logic [X_W-1:0]                  sprite_x,
    input  logic [Y_W-1:0]                  sprite_y,
    input  logic [NUM_STAGES*X_W-1:0]       act_x,
    input  logic [NUM_STAGES*Y_W-1:0]       act_y,
    input  logic [X_W-1:0]                  goal_x,
    input  logic [Y_W-1:0]                  goal_y,
    output logic                            draw_map,
    output logic                            draw_start,
    output logic [calc_sw(NUM_STAGES)-1:0]  stage,
    output logic [1:0]                      phase,
    output logic                            finished
);

    localparam int            SW   = calc_sw(NUM_STAGES);
    localparam logic [SW-1:0] LAST = SW'(NUM_STAGES);

    logic [1:0]            r_phase;
    logic [SW-1:0]         r_stage;
    logic                  r_act_q;
    logic                  r_draw_start;
    logic                  r_boot;

    logic [NUM_STAGES-1:0] w_at;
    logic                  w_at_goal;
    logic                  w_at_cur;
    logic                  w_at_prev;
    logic                  w_act_edge;
    logic                  w_dead;
    logic                  w_goal_ok;
    logic [1:0]            w_next_phase;
    logic [SW-1:0]         w_next_stage;
    logic                  w_enter_draw;

    coord_match #(
        .NUM_STAGES (NUM_STAGES),
        .X_W        (X_W),
        .Y_W        (Y_W)
    ) u_coord_match (
        .i_sprite_x (sprite_x),
        .i_sprite_y (sprite_y),
        .i_act_x    (act_x),
        .i_act_y    (act_y),
        .i_goal_x   (goal_x),
        .i_goal_y   (goal_y),
        .o_at       (w_at),
        .o_at_goal  (w_at_goal)
    );

    // Selecting by equality keeps stage 0 from having a "previous" point and
    // the last stage from having a "current" one, without out-of-range indexing.
    always_comb begin
        w_at_cur  = 1'b0;
        w_at_prev = 1'b0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            if (r_stage == SW'(k))     w_at_cur  = w_at[k];
            if (r_stage == SW'(k + 1)) w_at_prev = w_at[k];
        end
    end

    assign w_act_edge = activate & ~r_act_q;
    assign w_dead     = (DEAD_RESTART != 0) && sprite_dead;
    assign w_goal_ok  = (r_stage == LAST) && w_at_goal &&
                        (w_act_edge || (GOAL_NEEDS_ACT == 0));

    always_comb begin
        w_next_phase = r_phase;
        w_next_stage = r_stage;
        w_enter_draw = 1'b0;
        if (r_boot) begin
            w_enter_draw = 1'b1;
        end else begin
            case (r_phase)
                PH_DRAW: begin
                    // done_redraw alongside draw_start belongs to the previous redraw.
                    if (w_dead) begin
                        w_next_stage = '0;
                        w_enter_draw = 1'b1;
                    end else if (done_redraw && !activate && !r_draw_start) begin
                        w_next_phase = PH_PLAY;
                    end
                end
                PH_PLAY: begin
                    if (w_dead) begin
                        w_next_phase = PH_DRAW;
                        w_next_stage = '0;
                        w_enter_draw = 1'b1;
                    end else if (w_at_cur && w_act_edge) begin
                        w_next_phase = PH_DRAW;
                        w_next_stage = r_stage + SW'(1);
                        w_enter_draw = 1'b1;
                    end else if (w_at_prev && w_act_edge) begin
                        w_next_phase = PH_DRAW;
                        w_next_stage = r_stage - SW'(1);
                        w_enter_draw = 1'b1;
                    end else if (w_goal_ok) begin
                        w_next_phase = PH_DONE;
                    end
                end
                PH_DONE: begin
                end
                default: begin
                    w_next_phase = PH_DRAW;
                    w_next_stage = '0;
                    w_enter_draw = 1'b1;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_phase      <= PH_DRAW;
            r_stage      <= '0;
            r_act_q      <= 1'b0;
            r_draw_start <= 1'b0;
            r_boot       <= 1'b1;
        end else begin
            r_phase      <= w_next_phase;
            r_stage      <= w_next_stage;
            r_act_q      <= activate;
            r_draw_start <= w_enter_draw;
            r_boot       <= 1'b0;
        end
    end

    assign phase      = r_phase;
    assign stage      = r_stage;
    assign draw_start = r_draw_start;
    assign draw_map   = (r_phase == PH_DRAW);
    assign finished   = (r_phase == PH_DONE);

endmodule

// File: tb/tb_level_sequencer.sv
// Scoreboard bench: stimulus queues the expected (phase, stage, draw_start) changes,
// a negedge monitor pops one entry per observed output change.
module tb_level_sequencer;

    localparam int NS = 4;
    localparam int XW = 9;
    localparam int YW = 8;

    logic              clock       = 1'b0;
    logic              reset       = 1'b1;
    logic              activate    = 1'b0;
    logic              sprite_dead = 1'b0;
    logic              done_redraw = 1'b0;
    logic [XW-1:0]     sprite_x    = '0;
    logic [YW-1:0]     sprite_y    = '0;
    logic [NS*XW-1:0]  act_x       = '0;
    logic [NS*YW-1:0]  act_y       = '0;
    logic [XW-1:0]     goal_x      = '0;
    logic [YW-1:0]     goal_y      = '0;
    logic              draw_map;
    logic              draw_start;
    logic [2:0]        stage;
    logic [1:0]        phase;
    logic              finished;

    level_sequencer #(
        .NUM_STAGES     (NS),
        .X_W            (XW),
        .Y_W            (YW),
        .GOAL_NEEDS_ACT (0),
        .DEAD_RESTART   (1)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .activate    (activate),
        .sprite_dead (sprite_dead),
        .done_redraw (done_redraw),
        .sprite_x    (sprite_x),
        .sprite_y    (sprite_y),
        .act_x       (act_x),
        .act_y       (act_y),
        .goal_x      (goal_x),
        .goal_y      (goal_y),
        .draw_map    (draw_map),
        .draw_start  (draw_start),
        .stage       (stage),
        .phase       (phase),
        .finished    (finished)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [1:0] ph;
        logic [2:0] st;
        logic       ds;
    } ev_t;

    ev_t  exp_q[$];
    ev_t  prev_ev;
    ev_t  cur_ev;
    ev_t  exp_ev;
    logic mon_en = 1'b0;
    int   total  = 0;
    int   bad    = 0;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, want);
        end
    endtask

    always @(negedge clock) begin
        if (mon_en) begin
            cur_ev = '{ph: phase, st: stage, ds: draw_start};
            if (cur_ev != prev_ev) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_event: got ph=%0d st=%0d ds=%0d, expected no change",
                             phase, stage, draw_start);
                end else begin
                    exp_ev = exp_q.pop_front();
                    check("event {ph,st,ds,map,fin}",
                          {9'd0, phase, stage, draw_start, draw_map, finished},
                          {9'd0, exp_ev.ph, exp_ev.st, exp_ev.ds,
                           exp_ev.ph == 2'd0, exp_ev.ph == 2'd2});
                end
                prev_ev = cur_ev;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
        #1;
    endtask

    task automatic push(input logic [1:0] ph, input logic [2:0] st, input logic ds);
        exp_q.push_back('{ph: ph, st: st, ds: ds});
    endtask

    task automatic sync_check(input string name);
        tick(1);
        check(name, 16'(exp_q.size()), 16'd0);
    endtask

    task automatic set_point(input int k, input logic [XW-1:0] x, input logic [YW-1:0] y);
        act_x[k*XW +: XW] = x;
        act_y[k*YW +: YW] = y;
    endtask

    task automatic press_at(input logic [XW-1:0] x, input logic [YW-1:0] y);
        sprite_x = x;
        sprite_y = y;
        activate = 1'b1;
        tick(1);
        activate = 1'b0;
        tick(1);
    endtask

    task automatic finish_draw(input logic [2:0] st);
        push(2'd1, st, 1'b0);
        done_redraw = 1'b1;
        tick(1);
        done_redraw = 1'b0;
        sync_check("redraw_to_play");
    endtask

    task automatic advance(input logic [XW-1:0] x, input logic [YW-1:0] y, input logic [2:0] st);
        push(2'd0, st, 1'b1);
        push(2'd0, st, 1'b0);
        press_at(x, y);
        finish_draw(st);
    endtask

    initial begin
        set_point(0, 9'd124, 8'd158);
        set_point(1, 9'd192, 8'd154);
        set_point(2, 9'd180, 8'd215);
        set_point(3, 9'd124, 8'd158);
        goal_x = 9'd156;
        goal_y = 8'd55;

        // Reset held for three clock edges.
        tick(3);
        check("reset_phase", 16'(phase), 16'd0);
        check("reset_stage", 16'(stage), 16'd0);
        check("reset_draw_start", 16'(draw_start), 16'd0);
        check("reset_draw_map", 16'(draw_map), 16'd1);
        check("reset_finished", 16'(finished), 16'd0);
        reset   = 1'b0;
        prev_ev = '{ph: 2'd0, st: 3'd0, ds: 1'b0};
        mon_en  = 1'b1;
        push(2'd0, 3'd0, 1'b1);
        push(2'd0, 3'd0, 1'b0);
        tick(2);
        sync_check("boot_pulse");
        finish_draw(3'd0);
        check("boot_play", 16'(phase), 16'd1);

        // Held key: one advance, then DRAW holds while the key stays down.
        sprite_x = 9'd124;
        sprite_y = 8'd158;
        push(2'd0, 3'd1, 1'b1);
        push(2'd0, 3'd1, 1'b0);
        activate = 1'b1;
        tick(10);
        done_redraw = 1'b1;
        tick(10);
        check("held_key_draw", 16'(phase), 16'd0);
        done_redraw = 1'b0;
        activate    = 1'b0;
        tick(1);
        finish_draw(3'd1);
        tick(3);
        check("held_key_stage", 16'(stage), 16'd1);
        sync_check("held_key_quiet");

        advance(9'd192, 8'd154, 3'd2);

        // Rewind from stage 2 at point 1, key held through done_redraw.
        push(2'd0, 3'd1, 1'b1);
        push(2'd0, 3'd1, 1'b0);
        sprite_x = 9'd192;
        sprite_y = 8'd154;
        activate = 1'b1;
        tick(2);
        done_redraw = 1'b1;
        tick(3);
        sync_check("rewind");
        check("rewind_hold_draw", 16'(phase), 16'd0);
        push(2'd1, 3'd1, 1'b0);
        activate = 1'b0;
        tick(1);
        done_redraw = 1'b0;
        sync_check("rewind_release");

        advance(9'd192, 8'd154, 3'd2);

        // Death in the middle of the stage-3 redraw.
        push(2'd0, 3'd3, 1'b1);
        push(2'd0, 3'd3, 1'b0);
        press_at(9'd180, 8'd215);
        push(2'd0, 3'd0, 1'b1);
        push(2'd0, 3'd0, 1'b0);
        sprite_dead = 1'b1;
        tick(1);
        sprite_dead = 1'b0;
        tick(1);
        sync_check("death_restart");
        finish_draw(3'd0);

        advance(9'd124, 8'd158, 3'd1);
        advance(9'd192, 8'd154, 3'd2);
        advance(9'd180, 8'd215, 3'd3);

        // Points 2 and 3 coincide: forward wins; done_redraw in the draw_start cycle is stale.
        set_point(2, 9'd124, 8'd158);
        push(2'd0, 3'd4, 1'b1);
        push(2'd0, 3'd4, 1'b0);
        sprite_x = 9'd124;
        sprite_y = 8'd158;
        activate = 1'b1;
        tick(1);
        activate    = 1'b0;
        done_redraw = 1'b1;
        tick(1);
        done_redraw = 1'b0;
        tick(2);
        sync_check("coincident_forward");
        check("stale_done_ignored", 16'(phase), 16'd0);
        finish_draw(3'd4);
        set_point(2, 9'd180, 8'd215);

        // Goal reached without an activate edge.
        push(2'd2, 3'd4, 1'b0);
        sprite_x = 9'd156;
        sprite_y = 8'd55;
        tick(1);
        sync_check("goal_done");
        check("goal_finished", 16'(finished), 16'd1);
        check("goal_draw_map", 16'(draw_map), 16'd0);

        // DONE is absorbing.
        sprite_dead = 1'b1;
        activate    = 1'b1;
        done_redraw = 1'b1;
        tick(2);
        activate = 1'b0;
        tick(1);
        sprite_dead = 1'b0;
        done_redraw = 1'b0;
        press_at(9'd124, 8'd158);
        tick(2);
        sync_check("done_absorbing");
        check("done_phase", 16'(phase), 16'd2);
        check("done_stage", 16'(stage), 16'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
